// File: rtl/seq_sub_16_pkg.sv
// Shared types and constants for the digit-serial subtractor and its adder sibling.
// Holds the FSM state encoding, default widths and the signed-overflow helper.
package seq_sub_16_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DIGIT_DEF = 4;
   localparam int SLICE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Signed overflow from operand/result sign bits; is_sub selects a-b versus a+b.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
      return ((a_msb ^ b_msb) == is_sub) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/seq_sub_16_sub_4_bl.sv
// Combinational 4-bit borrow-lookahead subtract slice: {bout, diff} = a - b - bin.
// Also exports group propagate/generate so slices can be chained by lookahead.
module sub_4_bl
   import seq_sub_16_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               bin,
   output logic [SLICE_W-1:0] diff,
   output logic               bout,
   output logic               P,
   output logic               G
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = ~a & b;
   assign p = ~(a ^ b);

   // Borrow into each bit expanded directly from bin, no ripple chain.
   assign c[0] = bin;
   assign c[1] = g[0] | (p[0] & bin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);

   assign G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign P    = &p;
   assign c[4] = G | (P & bin);

   assign diff = a ^ b ^ c[SLICE_W-1:0];
   assign bout = c[4];

endmodule

// File: rtl/seq_sub_16.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, one DIGIT slice per
// clock, LSB first, with the borrow registered between slices.
module seq_sub_16
   import seq_sub_16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIGIT = DIGIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero,
   output state_e           dbg_state
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_e           state;
   state_e           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;

   logic [DIGIT-1:0] sl_a;
   logic [DIGIT-1:0] sl_b;
   logic [DIGIT-1:0] sl_diff;
   logic             sl_bout;
   logic             sl_p;
   logic             sl_g;
   logic             unused_pg;

   // One slice instance shared across all cycles; cnt selects the operand digit.
   assign sl_a      = a_r[int'(cnt)*DIGIT +: DIGIT];
   assign sl_b      = b_r[int'(cnt)*DIGIT +: DIGIT];
   assign unused_pg = sl_p ^ sl_g;

   sub_4_bl u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .bin  (borrow_r),
      .diff (sl_diff),
      .bout (sl_bout),
      .P    (sl_p),
      .G    (sl_g)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid never waits on ready, and DONE outputs hold until out_ready.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)     state_nx = CALC;
         CALC:    if (cnt == LAST)  state_nx = DONE;
         DONE:    if (out_ready)    state_nx = IDLE;
         default:                   state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      diff      = '0;
      bout      = 1'b0;
      ovf       = 1'b0;
      zero      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            diff      = diff_r;
            bout      = borrow_r;
            ovf       = signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], diff_r[WIDTH-1], 1'b1);
            zero      = (diff_r == '0);
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         a_r      <= '0;
         b_r      <= '0;
         borrow_r <= 1'b0;
         diff_r   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r      <= a;
               b_r      <= b;
               borrow_r <= bin;
               cnt      <= '0;
            end
            CALC: begin
               diff_r[int'(cnt)*DIGIT +: DIGIT] <= sl_diff;
               borrow_r                          <= sl_bout;
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
